// File: rtl/muldiv_pkg.sv
// Shared constants and state type for the RISC-V M-extension execute unit.
package muldiv_pkg;

    localparam logic [6:0] OP_REG        = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_core.sv
// Iterative magnitude datapath: shift-add multiply and restoring divide, one bit per step.
// Multiply and divide share one double-width accumulator; the final sign fix-up is
// applied to the post-step value so the top can capture the result on the last step.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 step,
    input  logic [2:0]           funct3,
    input  logic [WORD_SIZE-1:0] s1,
    input  logic [WORD_SIZE-1:0] s2,
    output logic [WORD_SIZE-1:0] result_next
);

    localparam int W = WORD_SIZE;

    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   mag_q, mag_d;
    logic [2:0]     op_q, op_d;
    logic           neg_lo_q, neg_lo_d;
    logic           neg_rem_q, neg_rem_d;

    logic           s1_signed, s2_signed, s1_neg, s2_neg, is_div;
    logic [W-1:0]   s1_mag, s2_mag;
    logic [W:0]     mul_sum, div_shift, div_diff;
    logic           div_fits;
    logic [2*W-1:0] prod_fixed;
    logic [W-1:0]   quot, rem;

    // Decide operand signedness for the incoming op and take magnitudes.
    always_comb begin
        s1_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                    (funct3 == F3_DIV) || (funct3 == F3_REM);
        s2_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                    (funct3 == F3_DIV) || (funct3 == F3_REM);
        s1_neg    = s1_signed && s1[W-1];
        s2_neg    = s2_signed && s2[W-1];
        s1_mag    = s1_neg ? -s1 : s1;
        s2_mag    = s2_neg ? -s2 : s2;
        is_div    = funct3[2];
    end

    // Load on start, otherwise advance one multiply or divide bit per step.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_q} : '0);
        div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff  = div_shift - {1'b0, mag_q};
        div_fits  = ~div_diff[W];
        acc_d     = acc_q;
        mag_d     = mag_q;
        op_d      = op_q;
        neg_lo_d  = neg_lo_q;
        neg_rem_d = neg_rem_q;
        if (start) begin
            acc_d     = {{W{1'b0}}, (is_div ? s1_mag : s2_mag)};
            mag_d     = is_div ? s2_mag : s1_mag;
            op_d      = funct3;
            // A zero divisor leaves the all-ones quotient unsigned; the remainder
            // comes back as |s1| re-signed, which is exactly the original s1.
            neg_lo_d  = (s1_neg ^ s2_neg) && !(is_div && (s2 == '0));
            neg_rem_d = is_div && s1_neg;
        end else if (step) begin
            if (op_q[2]) begin
                acc_d = {(div_fits ? div_diff[W-1:0] : div_shift[W-1:0]), acc_q[W-2:0], div_fits};
            end else begin
                acc_d = {mul_sum, acc_q[W-1:1]};
            end
        end
    end

    // Apply sign correction and pick the word the op returns.
    always_comb begin
        prod_fixed = neg_lo_q ? -acc_d : acc_d;
        quot       = acc_d[W-1:0];
        rem        = acc_d[2*W-1:W];
        case (op_q)
            F3_MUL:                       result_next = prod_fixed[W-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result_next = prod_fixed[2*W-1:W];
            F3_DIV, F3_DIVU:              result_next = neg_lo_q ? -quot : quot;
            default:                      result_next = neg_rem_q ? -rem : rem;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q     <= '0;
            mag_q     <= '0;
            op_q      <= '0;
            neg_lo_q  <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            mag_q     <= mag_d;
            op_q      <= op_d;
            neg_lo_q  <= neg_lo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

endmodule

// File: rtl/muldiv_execute.sv
// M-extension execute unit: FSM, D/E stall handshake, ROB tag and flush around muldiv_core.
module muldiv_execute
    import muldiv_pkg::*;
#(
    parameter int WORD_SIZE       = 32,
    parameter int ROB_ENTRY_WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       valid,
    input  logic [6:0]                 opcode,
    input  logic [6:0]                 funct7,
    input  logic [2:0]                 funct3,
    input  logic [WORD_SIZE-1:0]       s1,
    input  logic [WORD_SIZE-1:0]       s2,
    input  logic [ROB_ENTRY_WIDTH-1:0] rob_id,
    input  logic                       stall_in,
    output logic                       stall_out,
    output logic [WORD_SIZE-1:0]       result,
    output logic [ROB_ENTRY_WIDTH-1:0] rob_id_out,
    output logic                       valid_out
);

    localparam int              CNT_W    = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_SIZE - 1);

    muldiv_state_t              state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [ROB_ENTRY_WIDTH-1:0] tag_q, tag_d;
    logic [WORD_SIZE-1:0]       result_q, result_d;
    logic [ROB_ENTRY_WIDTH-1:0] rob_id_out_q, rob_id_out_d;

    logic                       is_muldiv, accept, core_step;
    logic [WORD_SIZE-1:0]       core_result;

    assign is_muldiv = valid && (opcode == OP_REG) && (funct7 == FUNCT7_MULDIV);
    assign accept    = !flush && is_muldiv &&
                       ((state_q == IDLE) || ((state_q == DONE) && !stall_in));
    assign core_step = (state_q == BUSY);

    // stall_out looks only at state and stall_in, never at valid, so D/E has no loop.
    assign stall_out  = (state_q == BUSY) || ((state_q == DONE) && stall_in);
    assign valid_out  = (state_q == DONE);
    assign result     = result_q;
    assign rob_id_out = rob_id_out_q;

    muldiv_core #(
        .WORD_SIZE(WORD_SIZE)
    ) u_core (
        .clk         (clk),
        .reset       (reset),
        .start       (accept),
        .step        (core_step),
        .funct3      (funct3),
        .s1          (s1),
        .s2          (s2),
        .result_next (core_result)
    );

    // Next-state logic; flush wins over accept and over the final BUSY step.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tag_d        = tag_q;
        result_d     = result_q;
        rob_id_out_d = rob_id_out_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    tag_d   = rob_id;
                end
            end
            BUSY: begin
                if (cnt_q == LAST_CNT) begin
                    state_d      = DONE;
                    result_d     = core_result;
                    rob_id_out_d = tag_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (!stall_in) begin
                    if (accept) begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        tag_d   = rob_id;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d      = IDLE;
            cnt_d        = '0;
            result_d     = result_q;
            rob_id_out_d = rob_id_out_q;
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tag_q        <= '0;
            result_q     <= '0;
            rob_id_out_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tag_q        <= tag_d;
            result_q     <= result_d;
            rob_id_out_q <= rob_id_out_d;
        end
    end

endmodule
